pred_pc_unit: RTL and testbench

PRED_PC_UNIT -- requirements
Module: pred_pc_unit

---
 rtl/y86_pkg.sv | 27 ++
 rtl/pred_pc_unit_if.sv | 28 ++
 rtl/ret_addr_stack.sv | 62 ++++++
 rtl/pred_pc_unit.sv | 106 ++++++++++
 tb/tb_pred_pc_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the fetch-side PC prediction slice.
//   word_t      : 64-bit machine word
//   I*          : instruction icode constants (IHALT..IPOPQ)
//   pc_state_e  : prediction FSM states (RUN, RET_WAIT)
package y86_pkg;

  typedef logic [63:0] word_t;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    RET_WAIT = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pred_pc_unit_if.sv
// Bundle between the fetch/memory/write-back pipeline and pred_pc_unit.
//   master : pipeline side (drives fetch info, stall, M/W stage status)
//   slave  : pred_pc_unit side (returns F_predPC, ret_stall, ras_used)
interface pred_pc_unit_if;
  import y86_pkg::*;

  logic       f_valid;
  logic [3:0] f_icode;
  word_t      f_valC;
  word_t      f_valP;
  logic       stall_F;
  logic [3:0] M_icode;
  logic       M_cnd;
  logic [3:0] W_icode;
  word_t      F_predPC;
  logic       ret_stall;
  logic       ras_used;

  modport master (
    output f_valid, f_icode, f_valC, f_valP, stall_F, M_icode, M_cnd, W_icode,
    input  F_predPC, ret_stall, ras_used
  );

  modport slave (
    input  f_valid, f_icode, f_valC, f_valP, stall_F, M_icode, M_cnd, W_icode,
    output F_predPC, ret_stall, ras_used
  );
endinterface

// File: rtl/ret_addr_stack.sv
// Circular return-address stack.
//   clk, rst_n : clock, async active-low reset (pointer/count only)
//   push       : write push_data at the write pointer; when full the oldest
//                entry is silently overwritten and count stays at DEPTH
//   pop        : discard the top entry
//   flush      : empty the stack; a simultaneous push still lands (count 1)
//   top        : most recently pushed live entry
//   count      : number of live entries, 0..DEPTH
module ret_addr_stack
  import y86_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  word_t                        push_data,
  output word_t                        top,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  word_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;

  // wr_ptr points at the next free slot; the top lives one below it.
  assign top = mem[wr_ptr - PW'(1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end else if (pop && !flush) begin
        wr_ptr <= wr_ptr - PW'(1);
      end

      if (flush) begin
        count <= push ? CW'(1) : '0;
      end else if (push) begin
        count <= (count == FULL) ? count : count + CW'(1);
      end else if (pop) begin
        count <= count - CW'(1);
      end
    end
  end

  // Entry storage carries no reset; only pointer and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pred_pc_unit.sv
// Fetch-stage next-PC predictor with optional return-address stack.
//   clk, rst_n : clock, async active-low reset
//   bus        : pred_pc_unit_if.slave
//                in : f_valid, f_icode, f_valC, f_valP, stall_F,
//                     M_icode, M_cnd, W_icode
//                out: F_predPC (registered prediction), ret_stall
//                     (fetch hold while an unpredicted ret is in flight),
//                     ras_used (registered, F_predPC came from the RAS)
// Build option: define PRED_PC_RAS_EN to implement the return-address stack;
// without it every ret waits for write-back and ras_used is tied low.
module pred_pc_unit
  import y86_pkg::*;
#(
  parameter int RAS_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  pred_pc_unit_if.slave  bus
);

  localparam logic [0:0] S_RUN      = 1'(RUN);
  localparam logic [0:0] S_RET_WAIT = 1'(RET_WAIT);
  localparam int         CNT_W      = $clog2(RAS_DEPTH + 1);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic             adv;
  logic             is_ret;
  logic             mispred;
  logic             ras_hit;
  word_t            ras_top;
  logic [CNT_W-1:0] ras_count;
  word_t            pred_pc_p0;
  word_t            pred_pc_p1;
  logic             ras_used_p1;

  assign is_ret        = (bus.f_icode == IRET);
  assign mispred       = (bus.M_icode == IJXX) && !bus.M_cnd;
  assign bus.ret_stall = (state == S_RET_WAIT) && (bus.W_icode != IRET);
  assign adv           = bus.f_valid && !bus.stall_F && !bus.ret_stall;

  // A mispredict flushes the stack this cycle, so a ret fetched alongside it
  // must not consume an entry that is about to be discarded.
  assign ras_hit = adv && is_ret && !mispred && (ras_count != '0);

`ifdef PRED_PC_RAS_EN
  ret_addr_stack #(
    .DEPTH     (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (adv && (bus.f_icode == ICALL)),
    .pop       (ras_hit),
    .flush     (mispred),
    .push_data (bus.f_valP),
    .top       (ras_top),
    .count     (ras_count)
  );

  assign bus.ras_used = ras_used_p1;
`else
  // No stack: behaves as a permanently empty RAS.
  assign ras_top      = '0;
  assign ras_count    = '0;
  assign bus.ras_used = 1'b0;
`endif

  always_comb begin
    pred_pc_p0 = bus.f_valP;
    if (bus.f_icode == IJXX || bus.f_icode == ICALL) begin
      pred_pc_p0 = bus.f_valC;
    end else if (ras_hit) begin
      pred_pc_p0 = ras_top;
    end
  end

  // A new unpredicted ret re-arms the wait even on the cycle the previous
  // ret retires, which is the only cycle adv can be high in RET_WAIT.
  always_comb begin
    state_nxt = state;
    if (state == S_RET_WAIT && bus.W_icode == IRET) begin
      state_nxt = S_RUN;
    end
    if (adv && is_ret && !ras_hit) begin
      state_nxt = S_RET_WAIT;
    end
  end

  // ---- stage p0 -> p1: predicted PC register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RUN;
      pred_pc_p1  <= '0;
      ras_used_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (adv) begin
        pred_pc_p1  <= pred_pc_p0;
        ras_used_p1 <= ras_hit;
      end
    end
  end

  assign bus.F_predPC = pred_pc_p1;

endmodule

// File: tb/tb_pred_pc_unit.sv
module tb_pred_pc_unit;
  import y86_pkg::*;

  localparam int DEPTH = 8;
`ifdef PRED_PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  typedef struct {
    word_t pc;
    bit    used;
    bit    rs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pred_pc_unit_if bus();

  pred_pc_unit #(.RAS_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural view of the predictor.
  exp_t  exp_q[$];
  word_t ras_q[$];
  bit    m_wait = 1'b0;
  word_t m_pc   = '0;
  bit    m_used = 1'b0;

  task automatic chk(input string name, input word_t act, input word_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    ras_q.delete();
    m_wait = 1'b0;
    m_pc   = '0;
    m_used = 1'b0;
  endtask

  // Called at a falling edge; drives one cycle of inputs, queues the outputs
  // expected during that cycle, advances the model past the next rising edge.
  task automatic step(input bit v, input logic [3:0] ic, input word_t vc,
                      input word_t vp, input bit st, input logic [3:0] mi,
                      input bit mc, input logic [3:0] wi);
    exp_t  e;
    bit    adv, mis, hit;
    word_t pred;
    bus.f_valid = v;  bus.f_icode = ic; bus.f_valC = vc; bus.f_valP = vp;
    bus.stall_F = st; bus.M_icode = mi; bus.M_cnd  = mc; bus.W_icode = wi;
    #1;
    e.pc = m_pc; e.used = m_used; e.rs = m_wait && (wi != IRET);
    exp_q.push_back(e);
    adv  = v && !st && !e.rs;
    mis  = (mi == IJXX) && !mc;
    hit  = 1'b0;
    pred = vp;
    if (ic == IJXX || ic == ICALL) pred = vc;
    else if (ic == IRET && adv && RAS_EN && !mis && ras_q.size() > 0) begin
      pred = ras_q[$];
      hit  = 1'b1;
    end
    if (mis) ras_q.delete();
    if (hit) void'(ras_q.pop_back());
    if (RAS_EN && adv && ic == ICALL) begin
      ras_q.push_back(vp);
      if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
    end
    if (m_wait && wi == IRET) m_wait = 1'b0;
    if (adv && ic == IRET && !hit) m_wait = 1'b1;
    if (adv) begin
      m_pc   = pred;
      m_used = hit;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [3:0] wi);
    step(1'b0, INOP, '0, '0, 1'b0, INOP, 1'b1, wi);
  endtask

  // Monitor: consumes one expectation per cycle, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("F_predPC", bus.F_predPC, e.pc);
        chk("ras_used", word_t'(bus.ras_used), word_t'(e.used));
        chk("ret_stall", word_t'(bus.ret_stall), word_t'(e.rs));
      end
    end
  end

  initial begin
    bus.f_valid = 1'b0; bus.f_icode = INOP; bus.f_valC = '0; bus.f_valP = '0;
    bus.stall_F = 1'b0; bus.M_icode = INOP; bus.M_cnd = 1'b1; bus.W_icode = INOP;

    repeat (2) @(negedge clk);
    chk("reset_pc", bus.F_predPC, 64'h0);
    chk("reset_used", word_t'(bus.ras_used), 64'h0);
    chk("reset_stall", word_t'(bus.ret_stall), 64'h0);
    rst_n = 1'b1;
    model_reset();

    // jXX predicts valC one cycle later
    step(1'b1, IJXX, 64'h100, 64'h10, 1'b0, INOP, 1'b1, INOP);
    chk("jxx_pc", bus.F_predPC, 64'h100);
    chk("jxx_used", word_t'(bus.ras_used), 64'h0);

    // stall holds, release loads valP
    step(1'b1, IOPQ, 64'h0, 64'h2A, 1'b1, INOP, 1'b1, INOP);
    chk("stall_hold", bus.F_predPC, 64'h100);
    step(1'b1, IOPQ, 64'h0, 64'h2A, 1'b0, INOP, 1'b1, INOP);
    chk("stall_release", bus.F_predPC, 64'h2A);

    // ret with empty stack waits for write-back
    step(1'b1, IRET, 64'h0, 64'h30, 1'b0, INOP, 1'b1, INOP);
    chk("ret_wait_stall", word_t'(bus.ret_stall), 64'h1);
    idle(INOP);
    idle(INOP);
    idle(IRET);
    idle(INOP);

    // two nested calls then two rets
    step(1'b1, ICALL, 64'h500, 64'h40, 1'b0, INOP, 1'b1, INOP);
    step(1'b1, ICALL, 64'h600, 64'h80, 1'b0, INOP, 1'b1, INOP);
    step(1'b1, IRET, 64'h0, 64'h700, 1'b0, INOP, 1'b1, INOP);
    if (RAS_EN) begin
      chk("ras_ret1_pc", bus.F_predPC, 64'h80);
      chk("ras_ret1_used", word_t'(bus.ras_used), 64'h1);
    end
    step(1'b1, IRET, 64'h0, 64'h710, 1'b0, INOP, 1'b1, INOP);
    if (RAS_EN) begin
      chk("ras_ret2_pc", bus.F_predPC, 64'h40);
      chk("ras_ret2_used", word_t'(bus.ras_used), 64'h1);
    end
    idle(IRET);

    // overflow: nine calls, nine rets
    for (int i = 1; i <= 9; i++)
      step(1'b1, ICALL, 64'h1000, word_t'(i), 1'b0, INOP, 1'b1, INOP);
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, IRET, 64'h0, 64'h2000, 1'b0, INOP, 1'b1, INOP);
      if (RAS_EN) begin
        if (i <= 8) chk("ovf_ret_pc", bus.F_predPC, word_t'(10 - i));
        else        chk("ovf_ret9_stall", word_t'(bus.ret_stall), 64'h1);
      end
    end
    idle(IRET);

    // mispredict in the same cycle as a ret: flush wins
    step(1'b1, ICALL, 64'h900, 64'h40, 1'b0, INOP, 1'b1, INOP);
    step(1'b1, IRET, 64'h0, 64'h910, 1'b0, IJXX, 1'b0, INOP);
    chk("mis_ret_stall", word_t'(bus.ret_stall), 64'h1);
    chk("mis_ret_used", word_t'(bus.ras_used), 64'h0);
    idle(INOP);
    idle(IRET);
    // stack must be empty: next ret is unpredicted
    step(1'b1, IRET, 64'h0, 64'h920, 1'b0, INOP, 1'b1, INOP);
    chk("after_flush_stall", word_t'(bus.ret_stall), 64'h1);

    // asynchronous reset while waiting
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", word_t'(bus.ret_stall), 64'h0);
    chk("async_rst_pc", bus.F_predPC, 64'h0);
    chk("async_rst_used", word_t'(bus.ras_used), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [3:0] ic, wi, mi;
      r = int'($urandom_range(0, 9));
      if (r < 3)      ic = ICALL;
      else if (r < 6) ic = IRET;
      else if (r < 7) ic = IJXX;
      else            ic = 4'($urandom_range(0, 11));
      wi = ($urandom_range(0, 3) == 0) ? IRET : 4'($urandom_range(0, 8));
      mi = ($urandom_range(0, 7) == 0) ? IJXX : INOP;
      step($urandom_range(0, 7) != 0, ic, {$urandom, $urandom},
           {$urandom, $urandom}, $urandom_range(0, 4) == 0, mi,
           1'($urandom_range(0, 1)), wi);
    end

    chk("queue_drained", word_t'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
